// File: rtl/pkg_instr_dec.sv
// rtl/pkg_instr_dec.sv - instruction group IDs, field decode types and pair-index helpers
//
// Shared by the fetch decoder and its head-word field extractor.
//   instr_group        : 3-bit group encoding (0 = unknown, 1..5 = groups)
//   fetch_dec_state_t  : sequential decoder state (head word / extension words)
//   decoded_instr_t    : fully decoded head word, also the output register layout
//   ig2_*/ig5_*        : report whether an index names a register pair

package pkg_instr_dec;

    typedef enum logic [2:0] {
        GRP_UNKNOWN = 3'd0,
        GRP_1       = 3'd1,
        GRP_2       = 3'd2,
        GRP_3       = 3'd3,
        GRP_4       = 3'd4,
        GRP_5       = 3'd5
    } instr_group;

    // Group identification prefixes, compared against the top bits of a head word.
    localparam logic       G1_ID = 1'b0;
    localparam logic [1:0] G2_ID = 2'b10;
    localparam logic [3:0] G3_ID = 4'b1100;
    localparam logic [3:0] G4_ID = 4'b1101;
    localparam logic [5:0] G5_ID = 6'b111000;

    typedef enum logic {
        FD_HEAD = 1'b0,
        FD_EXT  = 1'b1
    } fetch_dec_state_t;

    typedef struct packed {
        instr_group  grp;
        logic [5:0]  opcode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [7:0]  imm8;
        logic        ra_pair;
        logic        rb_pair;
        logic        illegal;
    } decoded_instr_t;

    // Group-2 opcodes 48..63 operate on a register pair in ra.
    function automatic logic ig2_get_ra_index_is_for_pair(input logic [5:0] op);
        return (op[5:4] == 2'b11);
    endfunction

    // Group-2 opcodes 56..63 additionally use a pair in rb.
    function automatic logic ig2_get_rb_index_is_for_pair(input logic [5:0] op);
        return (op[5:3] == 3'b111);
    endfunction

    // Group-5 opcodes 2,3,6,7 target a register pair in ra.
    function automatic logic ig5_get_ra_index_is_for_pair(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/instr_head_field_extract.sv
// rtl/instr_head_field_extract.sv - combinational group classification and field split of a head word
//
// Ports:
//   word   in   16-bit head word
//   fields out  decoded_instr_t; unused fields are zero, illegal=1 when no group matches

module instr_head_field_extract
    import pkg_instr_dec::*;
(
    input  logic [15:0]    word,
    output decoded_instr_t fields
);

    always_comb begin
        fields = '0;
        if (word[15] == G1_ID) begin
            fields.grp    = GRP_1;
            fields.opcode = {3'b000, word[14:12]};
            fields.ra     = word[11:8];
            fields.imm8   = word[7:0];
        end else if (word[15:14] == G2_ID) begin
            fields.grp     = GRP_2;
            fields.opcode  = word[13:8];
            fields.ra_pair = ig2_get_ra_index_is_for_pair(word[13:8]);
            fields.rb_pair = ig2_get_rb_index_is_for_pair(word[13:8]);
            // Pair operands are addressed by pair number, i.e. index / 2.
            fields.ra      = fields.ra_pair ? {1'b0, word[7:5]} : word[7:4];
            fields.rb      = fields.rb_pair ? {1'b0, word[3:1]} : word[3:0];
        end else if (word[15:12] == G3_ID) begin
            fields.grp    = GRP_3;
            fields.opcode = {4'b0000, word[11:10]};
            fields.ra     = word[9:6];
            fields.rb     = {1'b0, word[5:3]};
            fields.rc     = {1'b0, word[2:0]};
        end else if (word[15:12] == G4_ID) begin
            fields.grp    = GRP_4;
            fields.opcode = {2'b00, word[11:8]};
            fields.imm8   = word[7:0];
        end else if (word[15:10] == G5_ID) begin
            fields.grp     = GRP_5;
            fields.opcode  = {3'b000, word[9:7]};
            fields.ra_pair = ig5_get_ra_index_is_for_pair(word[9:7]);
            fields.ra      = fields.ra_pair ? {1'b0, word[6:4]} : word[6:3];
            fields.rb      = {1'b0, word[2:0]};
        end else begin
            fields.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_decoder.sv
// rtl/instr_fetch_decoder.sv - sequential instruction decoder with group-5 extension word collection
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 discard partial/held instruction
//   in_valid/in_ready     word input handshake, in_word = head or extension word
//   out_valid/out_ready   decoded packet handshake
//   out_group..out_illegal registered decoded packet fields

module instr_fetch_decoder
    import pkg_instr_dec::*;
#(
    parameter int WORD_W       = 16,
    parameter int REG_IDX_W    = 4,
    parameter int G5_EXT_WORDS = 1,
    parameter int IMM_W        = 16 * G5_EXT_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_group,
    output logic [5:0]           out_opcode,
    output logic [REG_IDX_W-1:0] out_ra,
    output logic [REG_IDX_W-1:0] out_rb,
    output logic [REG_IDX_W-1:0] out_rc,
    output logic [IMM_W-1:0]     out_imm,
    output logic                 out_ra_pair,
    output logic                 out_rb_pair,
    output logic                 out_illegal
);

    if (WORD_W != 16) begin : g_bad_word_w
        $error("instr_fetch_decoder: WORD_W must be 16");
    end
    if (G5_EXT_WORDS < 1 || G5_EXT_WORDS > 2) begin : g_bad_ext
        $error("instr_fetch_decoder: G5_EXT_WORDS must be 1 or 2");
    end
    if (IMM_W != 16 * G5_EXT_WORDS) begin : g_bad_imm_w
        $error("instr_fetch_decoder: IMM_W is derived and must not be overridden");
    end

    localparam logic EXT_LAST = 1'(G5_EXT_WORDS - 1);

    fetch_dec_state_t state_q, state_d;
    logic             ext_cnt_q, ext_cnt_d;
    decoded_instr_t   head_q, head_d;
    logic [IMM_W-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    decoded_instr_t   out_fields_q, out_fields_d;
    logic [IMM_W-1:0] out_ext_q, out_ext_d;

    decoded_instr_t   head_dec;
    logic             accept;
    logic [IMM_W-1:0] acc_shift;

    instr_head_field_extract u_extract (
        .word   (in_word[15:0]),
        .fields (head_dec)
    );

    always_comb begin
        in_ready  = !reset && !flush && (!out_valid_q || out_ready);
        accept    = in_valid && in_ready;
        // Earlier extension words end up in the upper bits.
        acc_shift = IMM_W'({acc_q, in_word[15:0]});

        state_d      = state_q;
        ext_cnt_d    = ext_cnt_q;
        head_d       = head_q;
        acc_d        = acc_q;
        out_valid_d  = out_valid_q;
        out_fields_d = out_fields_q;
        out_ext_d    = out_ext_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (state_q == FD_HEAD) begin
                if (head_dec.grp == GRP_5) begin
                    // Held packet may keep draining while extensions are collected.
                    head_d    = head_dec;
                    acc_d     = '0;
                    ext_cnt_d = 1'b0;
                    state_d   = FD_EXT;
                end else begin
                    out_fields_d = head_dec;
                    out_valid_d  = 1'b1;
                end
            end else begin
                acc_d     = acc_shift;
                ext_cnt_d = ext_cnt_q + 1'b1;
                if (ext_cnt_q == EXT_LAST) begin
                    out_fields_d = head_q;
                    out_ext_d    = acc_shift;
                    out_valid_d  = 1'b1;
                    ext_cnt_d    = 1'b0;
                    state_d      = FD_HEAD;
                end
            end
        end

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = FD_HEAD;
            ext_cnt_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FD_HEAD;
            ext_cnt_q    <= 1'b0;
            head_q       <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_fields_q <= '0;
            out_ext_q    <= '0;
        end else begin
            state_q      <= state_d;
            ext_cnt_q    <= ext_cnt_d;
            head_q       <= head_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_fields_q <= out_fields_d;
            out_ext_q    <= out_ext_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_group   = out_fields_q.grp;
    assign out_opcode  = out_fields_q.opcode;
    assign out_ra      = REG_IDX_W'(out_fields_q.ra);
    assign out_rb      = REG_IDX_W'(out_fields_q.rb);
    assign out_rc      = REG_IDX_W'(out_fields_q.rc);
    // Group 5 carries the collected extension words; every other group its 8-bit field (0 if none).
    assign out_imm     = (out_fields_q.grp == GRP_5) ? out_ext_q : IMM_W'(out_fields_q.imm8);
    assign out_ra_pair = out_fields_q.ra_pair;
    assign out_rb_pair = out_fields_q.rb_pair;
    assign out_illegal = out_fields_q.illegal;

endmodule

// File: tb/tb_instr_fetch_decoder.sv
// tb/tb_instr_fetch_decoder.sv - self-checking bench for instr_fetch_decoder with 1 and 2 extension words

module tb_instr_fetch_decoder;

    typedef struct packed {
        logic [2:0]  grp;
        logic [5:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [31:0] imm;
        logic        rap;
        logic        rbp;
        logic        ill;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst_s;
    logic        fl [2];
    logic        iv [2];
    logic        ordy [2];
    logic [15:0] iw [2];
    logic        ir [2];
    logic        ov [2];
    logic [2:0]  og [2];
    logic [5:0]  oop [2];
    logic [3:0]  ora [2];
    logic [3:0]  orb [2];
    logic [3:0]  orc [2];
    logic [31:0] oimm [2];
    logic        orap [2];
    logic        orbp [2];
    logic        oill [2];
    logic [15:0] imm0;
    logic [31:0] imm1;

    assign oimm[0] = {16'h0000, imm0};
    assign oimm[1] = imm1;

    always #5 clk = ~clk;

    instr_fetch_decoder #(.G5_EXT_WORDS(1)) dut0 (
        .clk(clk), .reset(rst_s), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_word(iw[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_group(og[0]), .out_opcode(oop[0]),
        .out_ra(ora[0]), .out_rb(orb[0]), .out_rc(orc[0]),
        .out_imm(imm0), .out_ra_pair(orap[0]), .out_rb_pair(orbp[0]),
        .out_illegal(oill[0])
    );

    instr_fetch_decoder #(.G5_EXT_WORDS(2)) dut1 (
        .clk(clk), .reset(rst_s), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_word(iw[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_group(og[1]), .out_opcode(oop[1]),
        .out_ra(ora[1]), .out_rb(orb[1]), .out_rc(orc[1]),
        .out_imm(imm1), .out_ra_pair(orap[1]), .out_rb_pair(orbp[1]),
        .out_illegal(oill[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference decode by numeric ranges of the head word.
    function automatic pkt_t ref_decode(input logic [15:0] w);
        pkt_t p;
        int   a, b;
        p = '0;
        if (w < 16'h8000) begin
            p.grp = 1; p.op = 6'((w >> 12) & 7); p.ra = 4'((w >> 8) & 15); p.imm = 32'(w & 255);
        end else if (w < 16'hC000) begin
            p.grp = 2; p.op = 6'((w >> 8) & 63);
            a = (w >> 4) & 15; b = w & 15;
            p.rap = (p.op >= 48); p.rbp = (p.op >= 56);
            p.ra = 4'(p.rap ? a / 2 : a); p.rb = 4'(p.rbp ? b / 2 : b);
        end else if (w < 16'hD000) begin
            p.grp = 3; p.op = 6'((w >> 10) & 3); p.ra = 4'((w >> 6) & 15);
            p.rb = 4'((w >> 3) & 7); p.rc = 4'(w & 7);
        end else if (w < 16'hE000) begin
            p.grp = 4; p.op = 6'((w >> 8) & 15); p.imm = 32'(w & 255);
        end else if (w < 16'hE400) begin
            p.grp = 5; p.op = 6'((w >> 7) & 7);
            a = (w >> 3) & 15;
            p.rap = ((p.op % 4) >= 2);
            p.ra = 4'(p.rap ? a / 2 : a); p.rb = 4'(w & 7);
        end else begin
            p.ill = 1'b1;
        end
        return p;
    endfunction

    // Model state per DUT
    logic        m_valid [2];
    logic        m_known [2];
    pkt_t        m_pkt [2];
    pkt_t        m_head [2];
    logic        m_ext [2];
    int          m_cnt [2];
    logic [31:0] m_acc [2];
    // Inputs captured at the sampling point, applied at the following edge
    logic        c_rst = 1'b1;
    logic        c_fl [2];
    logic        c_acc [2];
    logic        c_cons [2];
    logic [15:0] c_word [2];

    task automatic model_update();
        pkt_t p;
        for (int d = 0; d < 2; d++) begin
            if (c_rst) begin
                m_valid[d] = 0; m_known[d] = 1; m_pkt[d] = '0; m_ext[d] = 0; m_cnt[d] = 0;
            end else if (c_fl[d]) begin
                m_valid[d] = 0; m_known[d] = 0; m_ext[d] = 0; m_cnt[d] = 0;
            end else begin
                if (c_cons[d]) begin
                    m_valid[d] = 0; m_known[d] = 0;
                end
                if (c_acc[d]) begin
                    if (!m_ext[d]) begin
                        p = ref_decode(c_word[d]);
                        if (p.grp == 5) begin
                            m_head[d] = p; m_acc[d] = 0; m_cnt[d] = 0; m_ext[d] = 1;
                        end else begin
                            m_pkt[d] = p; m_valid[d] = 1; m_known[d] = 1;
                        end
                    end else begin
                        m_acc[d] = (m_acc[d] << 16) | 32'(c_word[d]);
                        if (d == 0) m_acc[d] = m_acc[d] & 32'h0000_FFFF;
                        m_cnt[d]++;
                        if (m_cnt[d] == d + 1) begin
                            m_pkt[d] = m_head[d]; m_pkt[d].imm = m_acc[d];
                            m_valid[d] = 1; m_known[d] = 1; m_ext[d] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic exp_ir;
        for (int d = 0; d < 2; d++) begin
            exp_ir = !rst_s && !fl[d] && (!m_valid[d] || ordy[d]);
            chk($sformatf("in_ready[%0d]", d), 32'(ir[d]), 32'(exp_ir));
            chk($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(m_valid[d]));
            if (m_known[d]) begin
                chk($sformatf("group[%0d]", d), 32'(og[d]), 32'(m_pkt[d].grp));
                chk($sformatf("opcode[%0d]", d), 32'(oop[d]), 32'(m_pkt[d].op));
                chk($sformatf("ra[%0d]", d), 32'(ora[d]), 32'(m_pkt[d].ra));
                chk($sformatf("rb[%0d]", d), 32'(orb[d]), 32'(m_pkt[d].rb));
                chk($sformatf("rc[%0d]", d), 32'(orc[d]), 32'(m_pkt[d].rc));
                chk($sformatf("imm[%0d]", d), oimm[d], m_pkt[d].imm);
                chk($sformatf("ra_pair[%0d]", d), 32'(orap[d]), 32'(m_pkt[d].rap));
                chk($sformatf("rb_pair[%0d]", d), 32'(orbp[d]), 32'(m_pkt[d].rbp));
                chk($sformatf("illegal[%0d]", d), 32'(oill[d]), 32'(m_pkt[d].ill));
            end
            c_fl[d]   = fl[d];
            c_acc[d]  = iv[d] && exp_ir;
            c_cons[d] = m_valid[d] && ordy[d];
            c_word[d] = iw[d];
        end
        c_rst = rst_s;
    endtask

    // One clock cycle: DUT d gets the given inputs, the other DUT idles.
    task automatic cyc(input int d, input logic v, input logic [15:0] w,
                       input logic rdy, input logic f, input logic r);
        @(posedge clk);
        model_update();
        #1;
        rst_s = r;
        for (int e = 0; e < 2; e++) begin
            iv[e]   = (e == d) ? v : 1'b0;
            iw[e]   = (e == d) ? w : 16'h0000;
            ordy[e] = (e == d) ? rdy : 1'b1;
            fl[e]   = (e == d) ? f : 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [15:0] w;
        int          d;
        rst_s = 1'b1;
        for (int e = 0; e < 2; e++) begin
            iv[e] = 0; iw[e] = 0; ordy[e] = 1; fl[e] = 0;
            c_fl[e] = 0; c_acc[e] = 0; c_cons[e] = 0; c_word[e] = 0;
            m_valid[e] = 0; m_known[e] = 0; m_pkt[e] = '0; m_head[e] = '0;
            m_ext[e] = 0; m_cnt[e] = 0; m_acc[e] = 0;
        end
        cyc(0, 1, 16'h3A5C, 1, 0, 1);
        cyc(0, 1, 16'h3A5C, 1, 0, 1);
        chk("reset_in_ready", 32'(ir[0]), 0);
        chk("reset_imm", oimm[1], 0);

        // Single g1 word
        cyc(0, 1, 16'h3A5C, 1, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0, 0);
        chk("g1_valid", 32'(ov[0]), 1);
        chk("g1_op", 32'(oop[0]), 3);
        chk("g1_ra", 32'(ora[0]), 32'hA);
        chk("g1_imm", oimm[0], 32'h5C);

        // Back-to-back stream
        cyc(0, 1, 16'h3A5C, 1, 0, 0);
        cyc(0, 1, 16'hD4FF, 1, 0, 0);
        chk("b2b_v1", 32'(ov[0]), 1);
        cyc(0, 1, 16'hC1D3, 1, 0, 0);
        chk("b2b_v2", 32'(ov[0]), 1);
        chk("g4_op", 32'(oop[0]), 4);
        chk("g4_imm", oimm[0], 32'hFF);
        cyc(0, 0, 16'h0000, 1, 0, 0);
        chk("b2b_v3", 32'(ov[0]), 1);
        chk("g3_ra", 32'(ora[0]), 7);
        chk("g3_rbp", 32'(orb[0]), 2);
        chk("g3_rcp", 32'(orc[0]), 3);

        // Group 5, one extension word
        cyc(0, 1, 16'hE12E, 1, 0, 0);
        cyc(0, 1, 16'hBEEF, 1, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0, 0);
        chk("g5_group", 32'(og[0]), 5);
        chk("g5_op", 32'(oop[0]), 2);
        chk("g5_ra", 32'(ora[0]), 2);
        chk("g5_rbp", 32'(orb[0]), 6);
        chk("g5_imm", oimm[0], 32'hBEEF);

        // Group 5, two extension words
        cyc(1, 1, 16'hE12E, 1, 0, 0);
        cyc(1, 1, 16'h1234, 1, 0, 0);
        cyc(1, 1, 16'h5678, 1, 0, 0);
        chk("g5x2_mid_valid", 32'(ov[1]), 0);
        cyc(1, 0, 16'h0000, 1, 0, 0);
        chk("g5x2_imm", oimm[1], 32'h1234_5678);

        // Stall for 5 cycles then release
        cyc(0, 1, 16'h3A5C, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 16'h0123, 0, 0, 0);
            chk("stall_in_ready", 32'(ir[0]), 0);
            chk("stall_imm", oimm[0], 32'h5C);
        end
        cyc(0, 1, 16'h0123, 1, 0, 0);
        chk("release_in_ready", 32'(ir[0]), 1);
        cyc(0, 0, 16'h0000, 1, 0, 0);

        // Flush mid-EXT
        cyc(0, 1, 16'hE12E, 1, 0, 0);
        cyc(0, 1, 16'h1111, 1, 1, 0);
        cyc(0, 1, 16'h8123, 1, 0, 0);
        chk("flush_valid", 32'(ov[0]), 0);
        cyc(0, 0, 16'h0000, 1, 0, 0);
        chk("g2_group", 32'(og[0]), 2);
        chk("g2_op", 32'(oop[0]), 1);
        chk("g2_ra", 32'(ora[0]), 2);
        chk("g2_rb", 32'(orb[0]), 3);

        // 0xF000 as head, then as extension data
        cyc(0, 1, 16'hF000, 1, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0, 0);
        chk("ill_flag", 32'(oill[0]), 1);
        chk("ill_group", 32'(og[0]), 0);
        cyc(0, 1, 16'hE12E, 1, 0, 0);
        cyc(0, 1, 16'hF000, 1, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0, 0);
        chk("ext_f000_imm", oimm[0], 32'hF000);
        chk("ext_f000_ill", 32'(oill[0]), 0);

        // Reset mid-EXT
        cyc(1, 1, 16'hE12E, 1, 0, 0);
        cyc(1, 0, 16'h0000, 1, 0, 1);
        cyc(1, 1, 16'h3A5C, 1, 0, 0);
        cyc(1, 0, 16'h0000, 1, 0, 0);
        chk("post_reset_group", 32'(og[1]), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            d = int'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: w = 16'hE000 | 16'($urandom_range(0, 16'h03FF));
                1: w = 16'hC000 | 16'($urandom_range(0, 16'h3FFF));
                2: w = 16'hF000 | 16'($urandom_range(0, 16'h0FFF));
                default: w = 16'($urandom);
            endcase
            cyc(d, ($urandom_range(0, 3) != 0), w, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 31) == 0), ($urandom_range(0, 127) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decoder.md
Name: instr_fetch_decoder

Overview:
- Sequential successor to the per-group combinational decoders. Accepts the instruction stream one 16-bit word per handshake and classifies the group (1-5 / unknown).
- Collects the extension words of group-5 instructions and emits one registered, fully decoded packet per instruction to the execute control.
- Sits between the instruction-fetch buffer and the CPU control FSM. Uses valid/ready on both sides, with stall and flush support.

Parameters:
- WORD_W, 16: instruction word width. Only 16 is legal; any other value is an elaboration error.
- REG_IDX_W, 4: register index width on all index outputs.
- G5_EXT_WORDS, 1: extension words following a group-5 head word (1..2). Immediate width is G5_EXT_WORDS*16.
- IMM_W, 16*G5_EXT_WORDS: width of out_imm. Derived; do not override.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of any partial or held instruction.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block accepts in_word this cycle.
- in_word  in  WORD_W  instruction word (head or extension).
- out_valid  out  1  decoded packet valid.
- out_ready  in  1  consumer takes the packet this cycle.
- out_group  out  3  pkg_instr_dec::instr_group encoding.
- out_opcode  out  6  group opcode, zero-extended.
- out_ra  out  REG_IDX_W  ra index, pair-shifted where applicable.
- out_rb  out  REG_IDX_W  rb / rbp index, zero-extended.
- out_rc  out  REG_IDX_W  rcp index (group 3 only), else 0.
- out_imm  out  IMM_W  g1/g4: 8-bit immediate zero-extended; g5: extension words, first word most significant; else 0.
- out_ra_pair, out_rb_pair  out  1 each  pair flags from package functions.
- out_illegal  out  1  head word matched no group.

Behaviour:
- Reset: state=HEAD, ext_cnt=0. out_valid=0 and all out_* fields=0. in_ready is 0 during the reset cycle.
- Handshakes:
  - A word is accepted when in_valid && in_ready.
  - A packet is consumed when out_valid && out_ready.
  - in_ready = !reset && !flush && (!out_valid || out_ready).
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
- Field decode of the head word, bits [15:0]:
  - g1, [15]=0: op[14:12], ra[11:8], imm[7:0].
  - g2, [15:14]=10: op[13:8], ra[7:4], rb[3:0]. ra/rb shifted right 1 when the ig2 pair functions return 1.
  - g3, [15:12]=1100: op[11:10], ra[9:6], rbp[5:3], rcp[2:0].
  - g4, [15:12]=1101: op[11:8], imm[7:0].
  - g5, [15:10]=111000: op[9:7], ra[6:3], rbp[2:0] (full 3-bit field). ra shifted right 1 when ig5 pair function returns 1.
  - Anything else: group unknown, out_illegal=1, all other fields 0.
- FSM:
  - HEAD:
    - Accepted non-g5 word: load output register, out_valid=1 next cycle (latency 1), remain in HEAD.
    - Accepted g5 word: latch head fields, ext_cnt=0, go to EXT. out_valid is unaffected, so a previous packet may still drain.
  - EXT:
    - Each accepted word is shifted into the immediate accumulator and increments ext_cnt.
    - On the word where ext_cnt==G5_EXT_WORDS-1: load output register, out_valid=1 next cycle, go to HEAD.
    - Extension words are never group-decoded. 0xF000 in EXT is data.
- Back-to-back: a packet consumed in the same cycle a new instruction completes is replaced without a bubble. Throughput is 1 packet/cycle for single-word streams.
- Flush (priority below reset, above everything else):
  - Next cycle: out_valid=0, state=HEAD, ext_cnt=0.
  - A word presented during flush is not accepted. Output fields may retain stale values but must not be qualified by out_valid.
- Reset or flush mid-EXT discards the partial instruction. The next accepted word is decoded as a head.

Decomposition:
- pkg_instr_dec (existing) holds:
  - instr_group typedef and all group-ID / field-range constants.
  - ig2_get_ra/rb_index_is_for_pair and ig5_get_ra_index_is_for_pair.
- Add to the package:
  - fetch_dec_state_t enum {FD_HEAD, FD_EXT}.
  - decoded_instr_t packed struct for the output register.
- Natural sub-module: instr_head_field_extract. Purely combinational; word in, decoded_instr_t out. The top keeps the FSM, accumulator and output register.

Test Plan:
- Reset, then in_word=0x3A5C, out_ready=1 -> next cycle out_valid=1, group=1, op=3, ra=0xA, imm=0x005C, illegal=0.
- Stream 0x3A5C, 0xD4FF, 0xC1D3 on consecutive cycles, out_ready=1 -> three packets on consecutive cycles, no bubble:
  - g4: op=4, imm=0xFF.
  - g3: op=0, ra=7, rbp=2, rcp=3.
- G5_EXT_WORDS=1: 0xE12E then 0xBEEF -> single packet one cycle after 0xBEEF: group=5, op=2, rbp=6, imm=0xBEEF. out_ra=5 or 2 per the ig5 pair function. Repeat with G5_EXT_WORDS=2 and extensions 0x1234, 0x5678 -> imm=0x12345678.
- out_ready=0 for 5 cycles with a packet held -> in_ready=0, fields stable. Release -> next word accepted that cycle.
- 0xE12E accepted, then flush asserted -> out_valid stays 0. Next word 0x8123 decodes as g2: op=1, ra/rb per pair functions from 2/3.
- 0xF000 as head -> out_illegal=1, group unknown. 0xF000 as g5 extension -> imm=0xF000, illegal=0.
